can_error_frame_gen: RTL and testbench
======================================

Name: can_error_frame_gen

Overview:
- Consumes the per-bit error monitors of the CAN receive path: the form monitor plus the stuff, CRC, ACK and bit monitors.
- On any detected error, drives a CAN error frame onto the bus output: a 6-bit error flag, then the delimiter sequence.
- Reports a latched error cause and an optional fault-confinement state.
- Sits directly downstream of the form-error monitor and its sibling monitors, and upstream of the bus driver mux.

Parameters:
- CLKS_PER_BIT, 10, clocks per CAN bit; set by the parent module, minimum 4.
- FLAG_BITS, 6, length of the error flag in bits.
- DELIM_BITS, 8, length of the error delimiter in bits.

Ports:
- Clock_TB  input  1  system clock; all logic is on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Bit_Entrada  input  1  sampled bus level (0 = dominant).
- Form_monitor  input  1  form error flag, registered by the upstream monitor.
- Stuff_monitor  input  1  stuff error flag.
- Crc_monitor  input  1  CRC error flag.
- Ack_monitor  input  1  ACK error flag.
- Bit_monitor  input  1  bit error flag.
- Is_Transmitter  input  1  1 while this node owns the current frame.
- Frame_Ok  input  1  one-cycle pulse marking a successful frame end.
- Bit_Saida  output  1  bus drive level (1 = recessive).
- Error_Active_Frame  output  1  high from the FLAG state until the error frame completes.
- Error_Code  output  5  latched cause {Bit, Stuff, Crc, Form, Ack}.
- Error_Done  output  1  one-cycle pulse when the delimiter finishes.
- Error_Passive  output  1  fault-confinement passive state.
- Tx_Err_Count  output  8  transmit error counter.
- Rx_Err_Count  output  8  receive error counter.

Behaviour:
- Reset values: Bit_Saida=1, Error_Active_Frame=0, Error_Code=0, Error_Done=0, Error_Passive=0, both counters=0, state=IDLE, Clk_Count=0, Bit_Count=0.
- Reset is synchronous; asserting it mid-frame aborts immediately, and the outputs take their reset values on the next edge.
- Any_Err = OR of the five monitor inputs.
- Bit timing:
  - Clk_Count runs 0..CLKS_PER_BIT-1 while the state is not IDLE.
  - Clk_Count is cleared on entry to FLAG.
  - Sample point: Clk_Count == CLKS_PER_BIT/2.
  - Bit end: Clk_Count == CLKS_PER_BIT-1. Bit_Count increments at bit end and is cleared on each state change.
- IDLE:
  - Bit_Saida=1.
  - If Any_Err=1 in a cycle, go to FLAG on the next edge.
  - On that same edge, Error_Code <= the monitor vector captured in that cycle.
  - Latency is 1 clock from error to dominant drive.
- FLAG:
  - Bit_Saida=0, or 1 if Error_Passive=1 (passive flag).
  - Error_Active_Frame=1.
  - After FLAG_BITS bit ends, go to DELIM_WAIT.
- DELIM_WAIT:
  - Bit_Saida=1.
  - At each sample point with Bit_Entrada=1, go to DELIM with Bit_Count=1 (first delimiter bit counted).
  - Bus held dominant by other nodes: remain in DELIM_WAIT, and also latch Error_Code[4] (bit error) at the first such sample.
  - After 7 more dominant bits in DELIM_WAIT, re-enter FLAG; Error_Code is unchanged.
- DELIM:
  - Bit_Saida=1.
  - A dominant sample at a sample point re-enters FLAG (form error); Error_Code[1] is set.
  - After DELIM_BITS total bits, pulse Error_Done for 1 clock, then return to IDLE with Error_Active_Frame=0.
- Monitor inputs are ignored in FLAG, DELIM_WAIT and DELIM, except as stated above.
- Error_Code holds until the next IDLE->FLAG transition overwrites it.
- Simultaneous Any_Err and Frame_Ok in IDLE: the error wins, and Frame_Ok is ignored for that cycle.

Optional Feature:
- Macro: CAN_ERR_COUNTERS_EN.
- With the macro:
  - On IDLE->FLAG: Tx_Err_Count += 8 if Is_Transmitter=1, else Rx_Err_Count += 1.
  - Counters saturate at 255.
  - On a Frame_Ok pulse in IDLE, both counters decrement by 1, floored at 0.
  - Error_Passive is registered, with value (Tx_Err_Count >= 128) || (Rx_Err_Count >= 128), updated one clock after a counter change.
- Without the macro: no counter registers exist; Tx_Err_Count=0, Rx_Err_Count=0 and Error_Passive=0 constantly.

Test Plan:
- Form error, Bit_Entrada=1 after the flag: Form_monitor=1 for 1 clock in IDLE -> Bit_Saida=0 on the next clock for exactly 60 clocks, then 1 for 80 clocks. Error_Done pulses once at clock 141. Error_Code=5'b00010.
- Stuff and CRC errors in the same cycle -> Error_Code=5'b01100, with a single error frame.
- Superposition: bus held 0 for 3 extra bits after the flag -> DELIM starts at the first recessive sample. Error_Done comes 30 clocks later than in the first scenario. Error_Code bit 4 is set.
- Dominant bit at delimiter bit 4 -> FLAG is re-entered with Bit_Saida=0. Error_Code[1]=1.
- Reset asserted at clock 20 of the flag -> Bit_Saida=1 and state IDLE on the next edge, with no Error_Done pulse.
- CAN_ERR_COUNTERS_EN with Is_Transmitter=1 and 16 errors:
  - Tx_Err_Count=128 and Error_Passive=1; the next flag drives Bit_Saida=1.
  - One Frame_Ok -> count 127 and Error_Passive=0.
  - Without the macro, Tx_Err_Count stays 0 throughout.

Source files
------------

// File: rtl/can_error_frame_gen.sv
// can_error_frame_gen
//   Turns the CAN receive-path error monitors into an error frame on the bus:
//   a FLAG_BITS-long error flag, a wait for the bus to go recessive, then a
//   DELIM_BITS-long recessive delimiter. The cause is latched in Error_Code.
//
//   Optional fault confinement: define CAN_ERR_COUNTERS_EN to build the
//   TX/RX error counters and the error-passive state. When it is undefined
//   the counters and Error_Passive are tied to 0.
//
// Ports
//   Clock_TB             system clock, rising edge
//   Reset                synchronous, active-high
//   Bit_Entrada          sampled bus level (0 = dominant)
//   *_monitor            per-bit error flags (form/stuff/crc/ack/bit)
//   Is_Transmitter       node owns the current frame
//   Frame_Ok             one-cycle pulse at a good frame end
//   Bit_Saida            bus drive level (1 = recessive)
//   Error_Active_Frame   high from FLAG entry until the frame completes
//   Error_Code           latched cause {Bit, Stuff, Crc, Form, Ack}
//   Error_Done           one-cycle pulse when the delimiter finishes
//   Error_Passive        fault-confinement passive state
//   Tx_Err_Count         transmit error counter
//   Rx_Err_Count         receive error counter
module can_error_frame_gen #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FLAG_BITS    = 6,
  parameter int DELIM_BITS   = 8
) (
  input  logic       Clock_TB,
  input  logic       Reset,
  input  logic       Bit_Entrada,
  input  logic       Form_monitor,
  input  logic       Stuff_monitor,
  input  logic       Crc_monitor,
  input  logic       Ack_monitor,
  input  logic       Bit_monitor,
  input  logic       Is_Transmitter,
  input  logic       Frame_Ok,
  output logic       Bit_Saida,
  output logic       Error_Active_Frame,
  output logic [4:0] Error_Code,
  output logic       Error_Done,
  output logic       Error_Passive,
  output logic [7:0] Tx_Err_Count,
  output logic [7:0] Rx_Err_Count
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  // DELIM_WAIT counts up to 7 dominant bits, so the counter must hold 8 too.
  localparam int BMAX = (FLAG_BITS > DELIM_BITS) ? FLAG_BITS : DELIM_BITS;
  localparam int BW   = $clog2(((BMAX > 8) ? BMAX : 8) + 1);

  typedef enum logic [1:0] {IDLE, FLAG, DELIM_WAIT, DELIM} state_t;

  state_t          state;
  logic [CW-1:0]   Clk_Count;
  logic [BW-1:0]   Bit_Count;
  logic [4:0]      mon_vec;
  logic            any_err;
  logic            sample_pt;
  logic            bit_end;

  assign mon_vec   = {Bit_monitor, Stuff_monitor, Crc_monitor, Form_monitor, Ack_monitor};
  assign any_err   = |mon_vec;
  assign sample_pt = (Clk_Count == CW'(CLKS_PER_BIT / 2));
  assign bit_end   = (Clk_Count == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge Clock_TB) begin
    if (Reset) begin
      state              <= IDLE;
      Clk_Count          <= '0;
      Bit_Count          <= '0;
      Bit_Saida          <= 1'b1;
      Error_Active_Frame <= 1'b0;
      Error_Code         <= '0;
      Error_Done         <= 1'b0;
    end else begin
      Error_Done <= 1'b0;
      // Bit timing free-runs outside IDLE; FLAG entry overrides with 0 below.
      if (state == IDLE) Clk_Count <= '0;
      else               Clk_Count <= bit_end ? '0 : Clk_Count + 1'b1;

      case (state)
        IDLE: begin
          Bit_Saida <= 1'b1;
          Bit_Count <= '0;
          if (any_err) begin
            state              <= FLAG;
            Bit_Saida          <= Error_Passive;  // passive flag is recessive
            Error_Active_Frame <= 1'b1;
            Error_Code         <= mon_vec;
          end
        end

        FLAG: begin
          if (bit_end) begin
            if (Bit_Count == BW'(FLAG_BITS - 1)) begin
              state     <= DELIM_WAIT;
              Bit_Saida <= 1'b1;
              Bit_Count <= '0;
            end else begin
              Bit_Count <= Bit_Count + 1'b1;
            end
          end
        end

        // Every sample seen here so far was dominant, so Bit_Count doubles
        // as the count of dominant bits after our flag.
        DELIM_WAIT: begin
          if (sample_pt) begin
            if (Bit_Entrada) begin
              state     <= DELIM;
              Bit_Count <= BW'(1);
            end else begin
              if (Bit_Count == '0) Error_Code[4] <= 1'b1;
              if (Bit_Count == BW'(7)) begin
                state     <= FLAG;
                Bit_Saida <= Error_Passive;
                Clk_Count <= '0;
                Bit_Count <= '0;
              end
            end
          end else if (bit_end) begin
            Bit_Count <= Bit_Count + 1'b1;
          end
        end

        // Bit_Count here is the number of the delimiter bit in progress.
        DELIM: begin
          if (sample_pt && !Bit_Entrada) begin
            state         <= FLAG;
            Error_Code[1] <= 1'b1;
            Bit_Saida     <= Error_Passive;
            Clk_Count     <= '0;
            Bit_Count     <= '0;
          end else if (bit_end) begin
            if (Bit_Count == BW'(DELIM_BITS)) begin
              state              <= IDLE;
              Error_Done         <= 1'b1;
              Error_Active_Frame <= 1'b0;
              Bit_Count          <= '0;
            end else begin
              Bit_Count <= Bit_Count + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef CAN_ERR_COUNTERS_EN
  always_ff @(posedge Clock_TB) begin
    if (Reset) begin
      Tx_Err_Count  <= '0;
      Rx_Err_Count  <= '0;
      Error_Passive <= 1'b0;
    end else begin
      if (state == IDLE && any_err) begin
        if (Is_Transmitter)
          Tx_Err_Count <= (Tx_Err_Count > 8'd247) ? 8'd255 : Tx_Err_Count + 8'd8;
        else if (Rx_Err_Count != 8'd255)
          Rx_Err_Count <= Rx_Err_Count + 8'd1;
      end else if (state == IDLE && Frame_Ok) begin
        if (Tx_Err_Count != '0) Tx_Err_Count <= Tx_Err_Count - 8'd1;
        if (Rx_Err_Count != '0) Rx_Err_Count <= Rx_Err_Count - 8'd1;
      end
      // Lags the counters by one clock.
      Error_Passive <= Tx_Err_Count[7] | Rx_Err_Count[7];
    end
  end
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{Is_Transmitter, Frame_Ok};
  assign Tx_Err_Count  = '0;
  assign Rx_Err_Count  = '0;
  assign Error_Passive = 1'b0;
`endif

endmodule

// File: tb/tb_can_error_frame_gen.sv
module tb_can_error_frame_gen;

`ifdef CAN_ERR_COUNTERS_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  logic       Clock_TB = 1'b0;
  logic       Reset = 1'b1;
  logic       Bit_Entrada = 1'b1;
  logic       Form_monitor = 1'b0, Stuff_monitor = 1'b0, Crc_monitor = 1'b0;
  logic       Ack_monitor = 1'b0, Bit_monitor = 1'b0;
  logic       Is_Transmitter = 1'b0, Frame_Ok = 1'b0;
  logic       Bit_Saida, Error_Active_Frame, Error_Done, Error_Passive;
  logic [4:0] Error_Code;
  logic [7:0] Tx_Err_Count, Rx_Err_Count;

  int total = 0;
  int bad   = 0;

  can_error_frame_gen #(.CLKS_PER_BIT(10), .FLAG_BITS(6), .DELIM_BITS(8)) dut (
    .Clock_TB(Clock_TB), .Reset(Reset), .Bit_Entrada(Bit_Entrada),
    .Form_monitor(Form_monitor), .Stuff_monitor(Stuff_monitor),
    .Crc_monitor(Crc_monitor), .Ack_monitor(Ack_monitor), .Bit_monitor(Bit_monitor),
    .Is_Transmitter(Is_Transmitter), .Frame_Ok(Frame_Ok),
    .Bit_Saida(Bit_Saida), .Error_Active_Frame(Error_Active_Frame),
    .Error_Code(Error_Code), .Error_Done(Error_Done), .Error_Passive(Error_Passive),
    .Tx_Err_Count(Tx_Err_Count), .Rx_Err_Count(Rx_Err_Count)
  );

  always #5 Clock_TB = ~Clock_TB;

  task automatic tick();
    @(posedge Clock_TB);
    #1;
  endtask

  // Pulses the monitors {Bit,Stuff,Crc,Form,Ack} for one clock, then measures
  // the dominant flag length and the recessive time until Error_Done.
  // The bus is held dominant for dom_ticks clocks after the flag ends.
  task automatic run_err(input logic [4:0] mon, input int dom_ticks,
                         output int low_n, output int hi_n,
                         output bit act, output bit glitch);
    {Bit_monitor, Stuff_monitor, Crc_monitor, Form_monitor, Ack_monitor} = mon;
    tick();
    {Bit_monitor, Stuff_monitor, Crc_monitor, Form_monitor, Ack_monitor} = 5'b0;
    act = Error_Active_Frame;
    low_n = 0;
    while (Bit_Saida === 1'b0 && low_n < 1000) begin low_n++; tick(); end
    if (dom_ticks > 0) Bit_Entrada = 1'b0;
    hi_n = 0;
    glitch = 1'b0;
    while (Error_Done !== 1'b1 && hi_n < 1000) begin
      if (Bit_Saida !== 1'b1) glitch = 1'b1;
      hi_n++;
      tick();
      if (hi_n == dom_ticks) Bit_Entrada = 1'b1;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    total++;
    if ({Bit_Saida, Error_Active_Frame, Error_Code, Error_Done, Error_Passive} !== 9'b1_0_00000_0_0 ||
        Tx_Err_Count !== 8'd0 || Rx_Err_Count !== 8'd0) begin
      bad++;
      $display("FAIL reset_values: saida=%b act=%b code=%b done=%b pas=%b tx=%0d rx=%0d, want 1 0 00000 0 0 0 0",
               Bit_Saida, Error_Active_Frame, Error_Code, Error_Done, Error_Passive, Tx_Err_Count, Rx_Err_Count);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_form();
    int lo, hi; bit act, gl;
    run_err(5'b00010, 0, lo, hi, act, gl);
    total++; if (lo !== 60) begin bad++; $display("FAIL form_flag_len: got %0d want 60", lo); end
    total++; if (hi !== 80) begin bad++; $display("FAIL form_delim_len: got %0d want 80", hi); end
    total++; if (gl !== 1'b0) begin bad++; $display("FAIL form_delim_recessive: got glitch=%b want 0", gl); end
    total++; if (act !== 1'b1) begin bad++; $display("FAIL form_active_in_flag: got %b want 1", act); end
    total++; if (Error_Code !== 5'b00010) begin bad++; $display("FAIL form_code: got %b want 00010", Error_Code); end
    total++; if (Error_Active_Frame !== 1'b0) begin bad++; $display("FAIL form_active_end: got %b want 0", Error_Active_Frame); end
    tick();
    total++; if (Error_Done !== 1'b0) begin bad++; $display("FAIL form_done_width: got %b want 0", Error_Done); end
  endtask

  task automatic test_stuff_crc();
    int lo, hi; bit act, gl;
    run_err(5'b01100, 0, lo, hi, act, gl);
    total++; if (Error_Code !== 5'b01100) begin bad++; $display("FAIL stuffcrc_code: got %b want 01100", Error_Code); end
    total++; if (lo !== 60 || hi !== 80) begin bad++; $display("FAIL stuffcrc_frame: got lo=%0d hi=%0d want 60 80", lo, hi); end
    tick();
  endtask

  task automatic test_superposition();
    int lo, hi; bit act, gl;
    run_err(5'b00010, 30, lo, hi, act, gl);
    total++; if (lo !== 60) begin bad++; $display("FAIL super_flag_len: got %0d want 60", lo); end
    total++; if (hi !== 110) begin bad++; $display("FAIL super_done_time: got %0d want 110", hi); end
    total++; if (Error_Code !== 5'b10010) begin bad++; $display("FAIL super_code: got %b want 10010", Error_Code); end
    tick();
  endtask

  task automatic test_delim_dominant();
    int n;
    Crc_monitor = 1'b1; tick(); Crc_monitor = 1'b0;
    repeat (60) tick();
    repeat (30) tick();          // now in delimiter bit 4, before its sample
    Bit_Entrada = 1'b0;
    repeat (10) tick();
    Bit_Entrada = 1'b1;
    total++; if (Bit_Saida !== 1'b0) begin bad++; $display("FAIL delim_reflag_drive: got %b want 0", Bit_Saida); end
    total++; if (Error_Code !== 5'b00110) begin bad++; $display("FAIL delim_code: got %b want 00110", Error_Code); end
    total++; if (Error_Active_Frame !== 1'b1) begin bad++; $display("FAIL delim_active: got %b want 1", Error_Active_Frame); end
    n = 0;
    while (Error_Done !== 1'b1 && n < 1000) begin n++; tick(); end
    total++; if (n !== 136) begin bad++; $display("FAIL delim_reflag_done: got %0d want 136", n); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    Form_monitor = 1'b1; tick(); Form_monitor = 1'b0;
    repeat (20) tick();
    total++; if (Bit_Saida !== 1'b0) begin bad++; $display("FAIL rstmid_in_flag: got %b want 0", Bit_Saida); end
    Reset = 1'b1; tick(); Reset = 1'b0;
    total++;
    if ({Bit_Saida, Error_Active_Frame, Error_Code} !== 7'b1_0_00000) begin
      bad++; $display("FAIL rstmid_abort: got saida=%b act=%b code=%b want 1 0 00000",
                      Bit_Saida, Error_Active_Frame, Error_Code);
    end
    seen = 0;
    repeat (200) begin
      if (Error_Done === 1'b1 || Bit_Saida !== 1'b1) seen++;
      tick();
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_idle: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_counters();
    int lo, hi, n; bit act, gl;
    Is_Transmitter = 1'b1;
    for (int k = 0; k < 16; k++) begin
      run_err(5'b01000, 0, lo, hi, act, gl);
      tick();
    end
    total++; if (Tx_Err_Count !== (CNT ? 8'd128 : 8'd0)) begin bad++; $display("FAIL cnt_tx16: got %0d want %0d", Tx_Err_Count, CNT ? 128 : 0); end
    total++; if (Error_Passive !== CNT) begin bad++; $display("FAIL cnt_passive: got %b want %b", Error_Passive, CNT); end
    total++; if (Rx_Err_Count !== 8'd0) begin bad++; $display("FAIL cnt_rx: got %0d want 0", Rx_Err_Count); end
    Stuff_monitor = 1'b1; tick(); Stuff_monitor = 1'b0;
    total++; if (Bit_Saida !== CNT) begin bad++; $display("FAIL cnt_passive_flag: got %b want %b", Bit_Saida, CNT); end
    n = 0;
    while (Error_Done !== 1'b1 && n < 1000) begin n++; tick(); end
    total++; if (n !== 140) begin bad++; $display("FAIL cnt_passive_frame: got %0d want 140", n); end
    tick();
    Is_Transmitter = 1'b0;
    repeat (8) begin Frame_Ok = 1'b1; tick(); Frame_Ok = 1'b0; tick(); end
    total++; if (Tx_Err_Count !== (CNT ? 8'd128 : 8'd0) || Error_Passive !== CNT) begin
      bad++; $display("FAIL cnt_dec8: got tx=%0d pas=%b want %0d %b", Tx_Err_Count, Error_Passive, CNT ? 128 : 0, CNT);
    end
    Frame_Ok = 1'b1; tick(); Frame_Ok = 1'b0;
    total++; if (Tx_Err_Count !== (CNT ? 8'd127 : 8'd0) || Error_Passive !== CNT) begin
      bad++; $display("FAIL cnt_dec_edge: got tx=%0d pas=%b want %0d %b", Tx_Err_Count, Error_Passive, CNT ? 127 : 0, CNT);
    end
    tick();
    total++; if (Error_Passive !== 1'b0) begin bad++; $display("FAIL cnt_passive_clear: got %b want 0", Error_Passive); end
  endtask

  initial begin
    test_reset();
    test_form();
    test_stuff_crc();
    test_superposition();
    test_delim_dominant();
    test_reset_mid_frame();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
